uart_comm_host: RTL and testbench

UART_COMM_HOST -- requirements
Module: uart_comm_host

---
 rtl/uart_comm_host.sv | 185 ++++++++++++++++++
 tb/tb_uart_comm_host.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_comm_host.sv
`default_nettype none
// ============================================================================
// Module  : uart_comm_host
// Brief   : Issues PING/INFO commands over a byte UART and parses the reply.
// Revision: 1.0 - initial release
// ============================================================================
module uart_comm_host #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic        cmd_type,
    output logic        cmd_ready,
    output logic        uart_tx_we,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_busy,
    input  logic        uart_rx_flag,
    input  logic [7:0]  uart_rx_byte,
    output logic        resp_valid,
    output logic [1:0]  resp_status,
    output logic [63:0] resp_info
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_RESP = 3'd2,
        S_RECV      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [1:0] c_ST_OK        = 2'd0;
    localparam logic [1:0] c_ST_INVALID   = 2'd1;
    localparam logic [1:0] c_ST_TIMEOUT   = 2'd2;
    localparam logic [1:0] c_ST_MALFORMED = 2'd3;

    state_t      r_state;
    logic        r_cmd_type;
    logic [2:0]  r_tx_idx;
    logic [15:0] r_timeout_cnt;
    logic [7:0]  r_rx_cnt;
    logic [7:0]  r_len;
    logic        r_info_type;
    logic [63:0] r_info_stage;
    logic        r_resp_valid;
    logic [1:0]  r_resp_status;
    logic [63:0] r_resp_info;

    logic        w_in_send;
    logic        w_tx_we;
    logic [7:0]  w_tx_byte;
    logic        w_last_tx;
    logic        w_timeout_hit;
    logic        w_len_ok;
    logic        w_type_ok;
    logic        w_last_rx;
    logic        w_shift_en;
    logic [63:0] w_stage_next;

    // The write strobe is gated combinationally so a busy FIFO never sees a write.
    assign w_in_send     = (r_state == S_SEND);
    assign w_tx_we       = w_in_send && !uart_tx_busy;
    assign w_tx_byte     = (r_cmd_type && (r_tx_idx == 3'd0)) ? 8'h08 : 8'h00;
    assign w_last_tx     = r_cmd_type ? (r_tx_idx == 3'd7) : 1'b1;
    assign w_timeout_hit = !uart_rx_flag && (r_timeout_cnt == TIMEOUT_CYCLES - 16'd1);
    assign w_len_ok      = (uart_rx_byte >= 8'd8) && (uart_rx_byte <= 8'd16);
    assign w_type_ok     = ((uart_rx_byte == 8'd0) && (r_len == 8'd16)) ||
                           ((uart_rx_byte == 8'd1) && (r_len == 8'd8));
    assign w_last_rx     = ((r_rx_cnt + 8'd1) == r_len);
    // Payload bytes 5..12 fill the 64-bit word, first byte ending up in [7:0].
    assign w_shift_en    = !r_info_type && (r_rx_cnt >= 8'd4) && (r_rx_cnt < 8'd12);
    assign w_stage_next  = w_shift_en ? {uart_rx_byte, r_info_stage[63:8]} : r_info_stage;

    assign cmd_ready    = (r_state == S_IDLE);
    assign uart_tx_we   = w_tx_we;
    assign uart_tx_data = w_in_send ? w_tx_byte : 8'h00;
    assign resp_valid   = r_resp_valid;
    assign resp_status  = r_resp_status;
    assign resp_info    = r_resp_info;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cmd_type    <= 1'b0;
            r_tx_idx      <= 3'd0;
            r_timeout_cnt <= 16'd0;
            r_rx_cnt      <= 8'd0;
            r_len         <= 8'd0;
            r_info_type   <= 1'b0;
            r_info_stage  <= 64'd0;
            r_resp_valid  <= 1'b0;
            r_resp_status <= c_ST_OK;
            r_resp_info   <= 64'd0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_type <= cmd_type;
                        r_tx_idx   <= 3'd0;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_tx_we) begin
                        if (w_last_tx) begin
                            r_timeout_cnt <= 16'd0;
                            r_rx_cnt      <= 8'd0;
                            r_info_type   <= 1'b0;
                            r_state       <= S_WAIT_RESP;
                        end else begin
                            r_tx_idx <= r_tx_idx + 3'd1;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (uart_rx_flag) begin
                        r_timeout_cnt <= 16'd0;
                        if (!r_cmd_type) begin
                            r_resp_status <= (uart_rx_byte == 8'h01) ? c_ST_OK : c_ST_MALFORMED;
                            r_resp_valid  <= 1'b1;
                            r_state       <= S_DONE;
                        end else if (!w_len_ok) begin
                            r_resp_status <= c_ST_MALFORMED;
                            r_resp_valid  <= 1'b1;
                            r_state       <= S_DONE;
                        end else begin
                            r_len    <= uart_rx_byte;
                            r_rx_cnt <= 8'd1;
                            r_state  <= S_RECV;
                        end
                    end else if (w_timeout_hit) begin
                        r_resp_status <= c_ST_TIMEOUT;
                        r_resp_valid  <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 16'd1;
                    end
                end
                S_RECV: begin
                    if (uart_rx_flag) begin
                        r_timeout_cnt <= 16'd0;
                        r_rx_cnt      <= r_rx_cnt + 8'd1;
                        r_info_stage  <= w_stage_next;
                        if (((r_rx_cnt == 8'd1) || (r_rx_cnt == 8'd2)) && (uart_rx_byte != 8'h00)) begin
                            r_resp_status <= c_ST_MALFORMED;
                            r_resp_valid  <= 1'b1;
                            r_state       <= S_DONE;
                        end else if (r_rx_cnt == 8'd3) begin
                            if (!w_type_ok) begin
                                r_resp_status <= c_ST_MALFORMED;
                                r_resp_valid  <= 1'b1;
                                r_state       <= S_DONE;
                            end else begin
                                r_info_type <= uart_rx_byte[0];
                            end
                        end else if (w_last_rx) begin
                            r_resp_status <= r_info_type ? c_ST_INVALID : c_ST_OK;
                            r_resp_valid  <= 1'b1;
                            r_state       <= S_DONE;
                            if (!r_info_type) begin
                                r_resp_info <= w_stage_next;
                            end
                        end
                    end else if (w_timeout_hit) begin
                        r_resp_status <= c_ST_TIMEOUT;
                        r_resp_valid  <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_comm_host.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_comm_host
// Brief   : Scoreboard bench for uart_comm_host command/response sequencing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_comm_host;

    localparam logic [15:0] TB_TIMEOUT = 16'd16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_type = 1'b0;
    logic        cmd_ready;
    logic        uart_tx_we;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy = 1'b0;
    logic        uart_rx_flag = 1'b0;
    logic [7:0]  uart_rx_byte = 8'h00;
    logic        resp_valid;
    logic [1:0]  resp_status;
    logic [63:0] resp_info;

    uart_comm_host #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_type     (cmd_type),
        .cmd_ready    (cmd_ready),
        .uart_tx_we   (uart_tx_we),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_rx_flag (uart_rx_flag),
        .uart_rx_byte (uart_rx_byte),
        .resp_valid   (resp_valid),
        .resp_status  (resp_status),
        .resp_info    (resp_info)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int we_count = 0;
    int resp_count = 0;
    int last_we_cyc = 0;
    int last_resp_cyc = 0;
    logic [7:0]  exp_tx_q[$];
    logic [65:0] exp_resp_q[$];
    logic [7:0]  rx_q[$];
    logic [63:0] model_info = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe and every response pulse is matched against the queues.
    always @(negedge clk) begin
        if (uart_tx_we === 1'b1) begin
            logic [7:0] e;
            we_count++;
            last_we_cyc = cyc;
            total++;
            if (uart_tx_busy !== 1'b0) begin
                bad++;
                $display("FAIL tx_while_busy: got we=1 busy=%b, required no write", uart_tx_busy);
            end
            total++;
            if (exp_tx_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got byte %h, required no strobe", uart_tx_data);
            end else begin
                e = exp_tx_q.pop_front();
                if (uart_tx_data !== e) begin
                    bad++;
                    $display("FAIL tx_byte: got %h required %h", uart_tx_data, e);
                end
            end
        end
        if (resp_valid === 1'b1) begin
            logic [65:0] r;
            resp_count++;
            last_resp_cyc = cyc;
            total++;
            if (exp_resp_q.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got status %0d, required no pulse", resp_status);
            end else begin
                r = exp_resp_q.pop_front();
                if (resp_status !== r[65:64]) begin
                    bad++;
                    $display("FAIL resp_status: got %0d required %0d", resp_status, r[65:64]);
                end
                total++;
                if (resp_info !== r[63:0]) begin
                    bad++;
                    $display("FAIL resp_info: got %h required %h", resp_info, r[63:0]);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic t);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            cycles(1);
            n++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_ready_wait: got %b required 1", cmd_ready);
        end
        if (t) begin
            exp_tx_q.push_back(8'h08);
            repeat (7) exp_tx_q.push_back(8'h00);
        end else begin
            exp_tx_q.push_back(8'h00);
        end
        cmd_type  = t;
        cmd_valid = 1'b1;
        cycles(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while (exp_tx_q.size() != 0 && n < 100) begin
            cycles(1);
            n++;
        end
        total++;
        if (exp_tx_q.size() != 0) begin
            bad++;
            $display("FAIL tx_drain: got %0d bytes pending, required 0", exp_tx_q.size());
            exp_tx_q.delete();
        end
    endtask

    task automatic send_rx(input int gap);
        while (rx_q.size() != 0) begin
            uart_rx_byte = rx_q.pop_front();
            uart_rx_flag = 1'b1;
            cycles(1);
            uart_rx_flag = 1'b0;
            cycles(gap);
        end
    endtask

    task automatic wait_resp_done(input int budget);
        int n = 0;
        while (exp_resp_q.size() != 0 && n < budget) begin
            cycles(1);
            n++;
        end
        total++;
        if (exp_resp_q.size() != 0) begin
            bad++;
            $display("FAIL resp_wait: got %0d responses pending, required 0", exp_resp_q.size());
            exp_resp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(3);
        total += 6;
        if (cmd_ready !== 1'b1)      begin bad++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
        if (uart_tx_we !== 1'b0)     begin bad++; $display("FAIL rst_tx_we: got %b required 0", uart_tx_we); end
        if (uart_tx_data !== 8'h00)  begin bad++; $display("FAIL rst_tx_data: got %h required 00", uart_tx_data); end
        if (resp_valid !== 1'b0)     begin bad++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
        if (resp_status !== 2'd0)    begin bad++; $display("FAIL rst_resp_status: got %0d required 0", resp_status); end
        if (resp_info !== 64'd0)     begin bad++; $display("FAIL rst_resp_info: got %h required 0", resp_info); end
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_ping();
        issue_cmd(1'b0);
        wait_tx_done();
        // A request while busy must be ignored: no extra bytes may appear.
        cmd_type  = 1'b1;
        cmd_valid = 1'b1;
        cycles(2);
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL busy_cmd_ready: got %b required 0", cmd_ready); end
        cmd_valid = 1'b0;
        exp_resp_q.push_back({2'd0, model_info});
        uart_rx_byte = 8'h01;
        uart_rx_flag = 1'b1;
        cycles(1);
        uart_rx_flag = 1'b0;
        total += 2;
        if (resp_valid !== 1'b1) begin bad++; $display("FAIL ping_valid: got %b required 1", resp_valid); end
        if (cmd_ready !== 1'b0)  begin bad++; $display("FAIL ping_done_ready: got %b required 0", cmd_ready); end
        cycles(1);
        total += 2;
        if (cmd_ready !== 1'b1)  begin bad++; $display("FAIL ping_ready_after: got %b required 1", cmd_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL ping_valid_width: got %b required 0", resp_valid); end
        wait_resp_done(5);
    endtask

    task automatic test_info_ok();
        logic [7:0] pkt[16] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0D, 8'h37, 8'h13,
                                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h5A, 8'hA5, 8'h5A, 8'hA5};
        issue_cmd(1'b1);
        wait_tx_done();
        model_info = 64'hDEADBEEF13370D13;
        exp_resp_q.push_back({2'd0, model_info});
        foreach (pkt[i]) rx_q.push_back(pkt[i]);
        send_rx(1);
        wait_resp_done(10);
        cycles(3);
        total++;
        if (resp_info !== 64'hDEADBEEF13370D13) begin
            bad++;
            $display("FAIL info_hold: got %h required deadbeef13370d13", resp_info);
        end
    endtask

    task automatic test_info_invalid();
        logic [7:0] pkt[8] = '{8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        issue_cmd(1'b1);
        wait_tx_done();
        exp_resp_q.push_back({2'd1, model_info});
        foreach (pkt[i]) rx_q.push_back(pkt[i]);
        // 15 idle cycles between bytes puts each byte on the timeout terminal count.
        send_rx(int'(TB_TIMEOUT) - 1);
        wait_resp_done(20);
    endtask

    task automatic test_tx_busy();
        int base;
        base = we_count;
        issue_cmd(1'b1);
        cycles(1);
        uart_tx_busy = 1'b1;
        cycles(3);
        uart_tx_busy = 1'b0;
        wait_tx_done();
        total++;
        if (we_count - base != 8) begin
            bad++;
            $display("FAIL busy_strobes: got %0d required 8", we_count - base);
        end
        exp_resp_q.push_back({2'd3, model_info});
        uart_rx_byte = 8'h05;
        uart_rx_flag = 1'b1;
        cycles(1);
        uart_rx_flag = 1'b0;
        total++;
        if (resp_valid !== 1'b1) begin bad++; $display("FAIL len_malformed_timing: got %b required 1", resp_valid); end
        wait_resp_done(5);
    endtask

    task automatic test_timeout();
        issue_cmd(1'b0);
        wait_tx_done();
        exp_resp_q.push_back({2'd2, model_info});
        wait_resp_done(40);
        // Strobe cycle plus 16 silent WAIT_RESP cycles before the DONE pulse.
        total++;
        if (last_resp_cyc - last_we_cyc != 17) begin
            bad++;
            $display("FAIL timeout_latency: got %0d required 17", last_resp_cyc - last_we_cyc);
        end
    endtask

    task automatic test_malformed();
        issue_cmd(1'b0);
        wait_tx_done();
        exp_resp_q.push_back({2'd3, model_info});
        rx_q.push_back(8'h02);
        send_rx(1);
        wait_resp_done(5);

        issue_cmd(1'b1);
        wait_tx_done();
        exp_resp_q.push_back({2'd3, model_info});
        rx_q.push_back(8'h08); rx_q.push_back(8'h05);
        send_rx(1);
        wait_resp_done(5);

        issue_cmd(1'b1);
        wait_tx_done();
        exp_resp_q.push_back({2'd3, model_info});
        rx_q.push_back(8'h08); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        send_rx(1);
        wait_resp_done(5);

        // Stray byte in IDLE: no pulse, status untouched.
        cycles(2);
        rx_q.push_back(8'h01);
        send_rx(4);
        total++;
        if (resp_status !== 2'd3) begin bad++; $display("FAIL stray_status: got %0d required 3", resp_status); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] pkt[6] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        issue_cmd(1'b1);
        wait_tx_done();
        foreach (pkt[i]) rx_q.push_back(pkt[i]);
        send_rx(1);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        model_info = 64'd0;
        total += 4;
        if (cmd_ready !== 1'b1)   begin bad++; $display("FAIL abort_ready: got %b required 1", cmd_ready); end
        if (resp_valid !== 1'b0)  begin bad++; $display("FAIL abort_valid: got %b required 0", resp_valid); end
        if (resp_status !== 2'd0) begin bad++; $display("FAIL abort_status: got %0d required 0", resp_status); end
        if (resp_info !== 64'd0)  begin bad++; $display("FAIL abort_info: got %h required 0", resp_info); end
        cycles(25);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            issue_cmd(1'b0);
            wait_tx_done();
            exp_resp_q.push_back({2'd0, model_info});
            rx_q.push_back(8'h01);
            send_rx(0);
            wait_resp_done(5);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ping();
        test_info_ok();
        test_info_invalid();
        test_tx_busy();
        test_timeout();
        test_malformed();
        test_reset_abort();
        test_back_to_back();
        cycles(3);
        total++;
        if (exp_tx_q.size() != 0 || exp_resp_q.size() != 0) begin
            bad++;
            $display("FAIL queues_empty: got tx=%0d resp=%0d required 0", exp_tx_q.size(), exp_resp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
